// File: rtl/pulse_stretch_variable_width_if.sv
// Bus bundle for pulse_stretch_variable_width.
//
// Purpose: groups the trigger/control inputs and the stretched-level outputs
// of the pulse stretcher so a producer and the stretcher share one port.
//
// Signals:
//   ld_en        state-update enable (0 freezes counters and flags)
//   Pulse_In     per-channel trigger pulses
//   Stretch_Len  stretch length in cycles, shared by all channels
//   Level_Out    per-channel stretched level
//   Done_d       per-channel "final high cycle of a stretch that ends here"
//   Drop_Flag    per-channel sticky "a pulse was ignored" flag
//   Busy         OR of Level_Out
//
// Handshake: there is no valid/ready pair. ld_en acts as a qualifier: inputs
// are consumed on every rising clk where ld_en=1 and are ignored otherwise.
//
// Modports:
//   master  drives ld_en/Pulse_In/Stretch_Len, observes the outputs
//   slave   the stretcher itself
interface pulse_stretch_variable_width_if #(
    parameter int Width       = 1,
    parameter int Count_Width = 8
);
    logic                   ld_en;
    logic [Width-1:0]       Pulse_In;
    logic [Count_Width-1:0] Stretch_Len;
    logic [Width-1:0]       Level_Out;
    logic [Width-1:0]       Done_d;
    logic [Width-1:0]       Drop_Flag;
    logic                   Busy;

    modport master (
        output ld_en, Pulse_In, Stretch_Len,
        input  Level_Out, Done_d, Drop_Flag, Busy
    );

    modport slave (
        input  ld_en, Pulse_In, Stretch_Len,
        output Level_Out, Done_d, Drop_Flag, Busy
    );
endinterface

// File: rtl/pulse_stretch_variable_width.sv
// pulse_stretch_variable_width
//
// Purpose: per-bit pulse-to-level converter. A one-cycle pulse on
// Pulse_In[i] holds Level_Out[i] high for Stretch_Len cycles, starting the
// cycle after the pulse is sampled.
//
// Ports:
//   clk   rising-edge clock
//   sres  synchronous active-high reset, overrides everything
//   bus   pulse_stretch_variable_width_if.slave (see interface header)
//
// Parameters:
//   Width        number of independent channels
//   Count_Width  width of Stretch_Len and of each channel's down-counter
//   Retrigger    1: a pulse during a stretch reloads the counter
//                0: such a pulse is dropped (sets Drop_Flag) unless the
//                   channel is in its last high cycle
//
// Per-channel state is just a down-counter plus the sticky drop flag;
// Level_Out and Busy decode from registers only.
module pulse_stretch_variable_width #(
    parameter int Width       = 1,
    parameter int Count_Width = 8,
    parameter int Retrigger   = 1
) (
    input logic clk,
    input logic sres,
    pulse_stretch_variable_width_if.slave bus
);

    localparam logic [Count_Width-1:0] CNT_ZERO = '0;
    localparam logic [Count_Width-1:0] CNT_ONE  = Count_Width'(1);
    localparam logic                   RETRIG   = (Retrigger != 0);

    logic [Width-1:0][Count_Width-1:0] cnt;
    logic [Width-1:0]                  drop_flag;

    logic [Width-1:0] load;
    logic [Width-1:0] drop;
    logic [Width-1:0] level;
    logic [Width-1:0] done;

    // Load/drop decisions. Without retrigger a load is still allowed when
    // cnt==1 so back-to-back stretches join without a gap.
    always_comb begin
        load  = '0;
        drop  = '0;
        level = '0;
        done  = '0;
        for (int i = 0; i < Width; i++) begin
            level[i] = (cnt[i] != CNT_ZERO);
            load[i]  = bus.ld_en & bus.Pulse_In[i] & (RETRIG | (cnt[i] <= CNT_ONE));
            drop[i]  = bus.ld_en & bus.Pulse_In[i] & ~RETRIG & (cnt[i] > CNT_ONE);
            done[i]  = bus.ld_en & ~sres & (cnt[i] == CNT_ONE) & ~load[i];
        end
    end

    always_ff @(posedge clk) begin
        if (sres) begin
            cnt       <= '0;
            drop_flag <= '0;
        end else if (bus.ld_en) begin
            for (int i = 0; i < Width; i++) begin
                if (load[i]) begin
                    // Stretch_Len=0 loads zero, which also cancels a
                    // running stretch when retriggering.
                    cnt[i] <= bus.Stretch_Len;
                end else if (cnt[i] != CNT_ZERO) begin
                    cnt[i] <= cnt[i] - CNT_ONE;
                end
                if (drop[i]) begin
                    drop_flag[i] <= 1'b1;
                end
            end
        end
    end

    assign bus.Level_Out = level;
    assign bus.Done_d    = done;
    assign bus.Drop_Flag = drop_flag;
    assign bus.Busy      = |level;

endmodule
